menu_overlay_render: RTL and testbench



---
 rtl/menu_overlay_render.sv | 166 ++++++++++++++++
 tb/tb_menu_overlay_render.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/menu_overlay_render.sv
// Menu overlay pixel fetch: per pixel strobe, reads the character code of the
// covering text cell and the matching font row from BRAM port B, then emits
// one overlay pixel exactly three clocks after the strobe. A one-entry cache
// (cell, row, code, font byte) skips both reads for repeated pixels of a row.
//
// state | meaning
// IDLE  | waiting for pix_ce; latches pixel coordinates and the hit decision
// CHAR  | text cell read issued (only on a miss)
// FONT  | code arrives; glyph row read issued (only on a miss)
// OUT   | font row arrives; overlay result registered, cache refreshed
module menu_overlay_render #(
    parameter logic [10:0] FONT_BASE = 11'h400,
    parameter logic [10:0] TEXT_BASE = 11'h000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        overlay_en_i,
    input  logic        pix_ce_i,
    input  logic [8:0]  x_i,
    input  logic [8:0]  y_i,
    input  logic        text_dirty_i,
    output logic [10:0] mem_addr_o,
    output logic        mem_ce_o,
    input  logic [7:0]  mem_dout_i,
    output logic        ovl_valid_o,
    output logic        ovl_active_o,
    output logic        ovl_pixel_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {IDLE, CHAR, FONT, OUT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        in_win_q, in_win_d;
    logic        hit_q, hit_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  font_q, font_d;
    logic [9:0]  cell_q, cell_d;
    logic [2:0]  row_q, row_d;
    logic        cache_valid_q, cache_valid_d;
    logic        ovl_valid_q, ovl_valid_d;
    logic        ovl_active_q, ovl_active_d;
    logic        ovl_pixel_q, ovl_pixel_d;
    logic        overrun_q, overrun_d;

    logic        in_win_in;
    logic        hit_in;
    logic        fetch;
    logic [7:0]  font_byte;

    // Window test and cache lookup on the incoming strobe; a coincident
    // text_dirty forces a miss.
    always_comb begin
        in_win_in = overlay_en_i && !x_i[8] && (y_i < 9'd224);
        hit_in    = cache_valid_q && !text_dirty_i
                    && ({y_i[7:3], x_i[7:3]} == cell_q) && (y_i[2:0] == row_q);
        fetch     = in_win_q && !hit_q;
        font_byte = hit_q ? font_q : mem_dout_i;
    end

    // Next-state, BRAM port B control and result computation.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        in_win_d      = in_win_q;
        hit_d         = hit_q;
        code_d        = code_q;
        font_d        = font_q;
        cell_d        = cell_q;
        row_d         = row_q;
        cache_valid_d = cache_valid_q;
        ovl_valid_d   = 1'b0;
        ovl_active_d  = ovl_active_q;
        ovl_pixel_d   = ovl_pixel_q;
        overrun_d     = overrun_q;
        mem_ce_o      = 1'b0;
        mem_addr_o    = '0;

        if (text_dirty_i) cache_valid_d = 1'b0;
        if (pix_ce_i && (state_q != IDLE)) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pix_ce_i) begin
                    x_d      = x_i[7:0];
                    y_d      = y_i[7:0];
                    in_win_d = in_win_in;
                    hit_d    = hit_in;
                    state_d  = CHAR;
                end
            end
            CHAR: begin
                if (fetch) begin
                    mem_ce_o   = 1'b1;
                    mem_addr_o = TEXT_BASE + {1'b0, y_q[7:3], x_q[7:3]};
                end
                state_d = FONT;
            end
            FONT: begin
                if (fetch) begin
                    mem_ce_o   = 1'b1;
                    mem_addr_o = FONT_BASE + {1'b0, mem_dout_i[6:0], y_q[2:0]};
                    code_d     = mem_dout_i;
                end
                state_d = OUT;
            end
            OUT: begin
                ovl_valid_d  = 1'b1;
                ovl_active_d = in_win_q;
                ovl_pixel_d  = in_win_q && (font_byte[x_q[2:0]] ^ code_q[7]);
                if (fetch) begin
                    font_d        = mem_dout_i;
                    cell_d        = {y_q[7:3], x_q[7:3]};
                    row_d         = y_q[2:0];
                    cache_valid_d = !text_dirty_i;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            in_win_q      <= 1'b0;
            hit_q         <= 1'b0;
            code_q        <= '0;
            font_q        <= '0;
            cell_q        <= '0;
            row_q         <= '0;
            cache_valid_q <= 1'b0;
            ovl_valid_q   <= 1'b0;
            ovl_active_q  <= 1'b0;
            ovl_pixel_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            in_win_q      <= in_win_d;
            hit_q         <= hit_d;
            code_q        <= code_d;
            font_q        <= font_d;
            cell_q        <= cell_d;
            row_q         <= row_d;
            cache_valid_q <= cache_valid_d;
            ovl_valid_q   <= ovl_valid_d;
            ovl_active_q  <= ovl_active_d;
            ovl_pixel_q   <= ovl_pixel_d;
            overrun_q     <= overrun_d;
        end
    end

    assign ovl_valid_o  = ovl_valid_q;
    assign ovl_active_o = ovl_active_q;
    assign ovl_pixel_o  = ovl_pixel_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_menu_overlay_render.sv
// Bench for menu_overlay_render: BRAM port B model plus a vector table of
// strobes, followed by hand-written overrun and reset-abort sequences.
module tb_menu_overlay_render;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        overlay_en = 1'b0;
    logic        pix_ce = 1'b0;
    logic [8:0]  x = '0;
    logic [8:0]  y = '0;
    logic        text_dirty = 1'b0;
    logic [10:0] mem_addr;
    logic        mem_ce;
    logic [7:0]  mem_dout = '0;
    logic        ovl_valid;
    logic        ovl_active;
    logic        ovl_pixel;
    logic        overrun;

    logic [7:0]  bram [0:2047];

    int checks = 0;
    int failures = 0;

    menu_overlay_render dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .overlay_en_i(overlay_en),
        .pix_ce_i    (pix_ce),
        .x_i         (x),
        .y_i         (y),
        .text_dirty_i(text_dirty),
        .mem_addr_o  (mem_addr),
        .mem_ce_o    (mem_ce),
        .mem_dout_i  (mem_dout),
        .ovl_valid_o (ovl_valid),
        .ovl_active_o(ovl_active),
        .ovl_pixel_o (ovl_pixel),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    // Registered-read BRAM: data valid one clock after mem_ce.
    always @(posedge clk) if (mem_ce) mem_dout <= bram[mem_addr];

    typedef struct {
        logic        wr;
        logic [10:0] wa;
        logic [7:0]  wd;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        en;
        logic        dirty;
        int          nce;
        logic [10:0] a0;
        logic [10:0] a1;
        logic        act;
        logic        pix;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic wr, logic [10:0] wa, logic [7:0] wd,
                                logic [8:0] xv, logic [8:0] yv, logic en, logic dirty,
                                int nce, logic [10:0] a0, logic [10:0] a1,
                                logic act, logic pix);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.x = xv; v.y = yv; v.en = en;
        v.dirty = dirty; v.nce = nce; v.a0 = a0; v.a1 = a1; v.act = act; v.pix = pix;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // One strobe with 4-clock spacing; samples #1 after each edge.
    task automatic run_strobe(input vec_t v, input int idx);
        int          nce;
        logic [10:0] a0;
        logic [10:0] a1;
        logic        early;
        nce = 0; a0 = '0; a1 = '0; early = 1'b0;
        if (v.wr) bram[v.wa] = v.wd;
        x = v.x; y = v.y; overlay_en = v.en; text_dirty = v.dirty; pix_ce = 1'b1;
        @(posedge clk); #1;
        pix_ce = 1'b0; text_dirty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ovl_valid) early = 1'b1;
            if (mem_ce) begin
                if (nce == 0) a0 = mem_addr; else a1 = mem_addr;
                nce++;
            end
            @(posedge clk); #1;
        end
        check("valid_early", idx, 32'(early), 32'd0);
        check("valid_t3", idx, 32'(ovl_valid), 32'd1);
        check("mem_ce_cycles", idx, nce, v.nce);
        if (v.nce == 2) begin
            check("addr_cell", idx, 32'(a0), 32'(v.a0));
            check("addr_glyph", idx, 32'(a1), 32'(v.a1));
        end
        check("active", idx, 32'(ovl_active), 32'(v.act));
        check("pixel", idx, 32'(ovl_pixel), 32'(v.pix));
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 2048; i++) bram[i] = 8'h00;
        bram[11'h000] = 8'h41;
        bram[11'h608] = 8'h0C;
        bram[11'h37F] = 8'hB1;
        bram[11'h58F] = 8'h5A;
        bram[11'h609] = 8'h81;

        // Font row 0x0C -> pixels 0,0,1,1,0,0,0,0 left to right.
        vecs[0]  = mk(0, 0, 0, 9'd0,   9'd0,   1, 0, 2, 11'h000, 11'h608, 1, 0);
        vecs[1]  = mk(0, 0, 0, 9'd1,   9'd0,   1, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 9'd2,   9'd0,   1, 0, 0, 0, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0, 9'd3,   9'd0,   1, 0, 0, 0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 9'd4,   9'd0,   1, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 9'd5,   9'd0,   1, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 9'd6,   9'd0,   1, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 9'd7,   9'd0,   1, 0, 0, 0, 0, 1, 0);
        // Last cell, inverse glyph 0x31 row 7: font 0x5A bit7=0 -> pixel 1.
        vecs[8]  = mk(0, 0, 0, 9'd255, 9'd223, 1, 0, 2, 11'h37F, 11'h58F, 1, 1);
        vecs[9]  = mk(0, 0, 0, 9'd256, 9'd0,   1, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 9'd2,   9'd0,   0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 9'd2,   9'd0,   1, 0, 2, 11'h000, 11'h608, 1, 1);
        vecs[12] = mk(0, 0, 0, 9'd3,   9'd0,   1, 0, 0, 0, 0, 1, 1);
        // Text rewritten to 0xC1 with coincident dirty: miss, inverse 'A'.
        vecs[13] = mk(1, 11'h000, 8'hC1, 9'd3, 9'd0, 1, 1, 2, 11'h000, 11'h608, 1, 0);
        vecs[14] = mk(0, 0, 0, 9'd4,   9'd0,   1, 0, 0, 0, 0, 1, 1);
        // Same cell, next row: miss, font 0x81 bit0=1 inverted -> 0.
        vecs[15] = mk(0, 0, 0, 9'd0,   9'd1,   1, 0, 2, 11'h000, 11'h609, 1, 0);
        vecs[16] = mk(0, 0, 0, 9'd0,   9'd224, 1, 0, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 0, 32'(ovl_valid), 0);
        check("rst_active", 0, 32'(ovl_active), 0);
        check("rst_pixel", 0, 32'(ovl_pixel), 0);
        check("rst_overrun", 0, 32'(overrun), 0);
        check("rst_mem_ce", 0, 32'(mem_ce), 0);
        check("rst_mem_addr", 0, 32'(mem_addr), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_strobe(vecs[i], i);

        // Overrun: strobes at T and T+2 give a single result.
        check("overrun_pre", 100, 32'(overrun), 0);
        x = 9'd1; y = 9'd0; overlay_en = 1'b1; pix_ce = 1'b1;
        @(posedge clk); #1; pix_ce = 1'b0;
        @(posedge clk); #1; pix_ce = 1'b1;
        @(posedge clk); #1; pix_ce = 1'b0;
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (ovl_valid) cnt++;
            @(posedge clk); #1;
        end
        check("overrun_valid_count", 101, cnt, 1);
        check("overrun_set", 101, 32'(overrun), 1);
        check("overrun_pixel", 101, 32'(ovl_pixel), 1);
        repeat (3) @(posedge clk);
        #1;
        check("overrun_sticky", 102, 32'(overrun), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("overrun_cleared", 103, 32'(overrun), 0);
        check("rst2_active", 103, 32'(ovl_active), 0);
        check("rst2_pixel", 103, 32'(ovl_pixel), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Reset one clock into a miss aborts it.
        x = 9'd2; y = 9'd0; overlay_en = 1'b1; pix_ce = 1'b1;
        @(posedge clk); #1; pix_ce = 1'b0; resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_ce", 104, 32'(mem_ce), 0);
        check("abort_valid", 104, 32'(ovl_valid), 0);
        @(posedge clk); #1; resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (ovl_valid) cnt++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", 105, cnt, 0);
        // First strobe after reset misses even though the cell was cached.
        run_strobe(mk(0, 0, 0, 9'd2, 9'd0, 1, 0, 2, 11'h000, 11'h608, 1, 0), 106);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
